rvb_zbb32_arbiter: RTL and testbench
====================================

Name: rvb_zbb32_arbiter

Overview:
Shares one rvb_zbb32 execution unit between two independent requester ports, such as two issue slots or a core plus a debug/self-test port.
- Arbitrates the din side round-robin.
- Tracks the owner of every in-flight operation in an ID FIFO.
- Routes each dout result back to the requester that issued it.
- The shared unit completes in order, so FIFO order equals completion order.

Parameters:
XLEN, 32, operand/result width; must match the shared unit.
DEPTH, 4, maximum outstanding operations (ID FIFO depth); power of two, >= 2.

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 operation valid
req0_ready  out  1  requester 0 operation accepted
req0_rs1  in  XLEN  requester 0 operand 1
req0_rs2  in  XLEN  requester 0 operand 2
req0_insn  in  32  requester 0 instruction word
rsp0_valid  out  1  requester 0 result valid
rsp0_ready  in  1  requester 0 result accept
rsp0_rd  out  XLEN  requester 0 result
req1_* / rsp1_*  same as port 0, for requester 1
unit_din_valid  out  1  to shared unit din_valid
unit_din_ready  in  1  from shared unit din_ready
unit_din_rs1  out  XLEN  to shared unit din_rs1
unit_din_rs2  out  XLEN  to shared unit din_rs2
unit_din_insn  out  32  to shared unit din_insn
unit_dout_valid  in  1  from shared unit dout_valid
unit_dout_ready  out  1  to shared unit dout_ready
unit_dout_rd  in  XLEN  from shared unit dout_rd

Behaviour:
- Handshakes: a transfer occurs on a rising clock edge where valid && ready. Requesters hold valid and payload stable until accepted.
- State:
  - prio: 1 bit; the port favoured on a tie. Resets to 0.
  - lock: 1 bit plus lock_id. Set while a presented request is stalled.
  - ID FIFO: DEPTH entries of 1 bit, with rd/wr pointers and a count 0..DEPTH.
- Grant selection, combinational:
  - If lock is set, grant = lock_id.
  - Else if only one reqN_valid is high, grant = that port.
  - Else if both are high, grant = prio.
- unit_din_valid = req[grant]_valid && !full. unit_din_rs1/rs2/insn are muxed from the granted port.
- req[grant]_ready = unit_din_ready && !full. The non-granted port's ready = 0.
- Issue transfer (unit_din_valid && unit_din_ready):
  - Push grant into the ID FIFO.
  - prio <= ~grant.
  - Clear lock.
- unit_din_valid high without unit_din_ready: lock <= 1, lock_id <= grant. This prevents the request presented to the unit from changing mid-handshake.
- full (count == DEPTH) blocks issue even when a pop happens in the same cycle. No bypass; the one-cycle bubble is accepted.
- Response routing, combinational, using head = FIFO front:
  - rsp[head]_valid = unit_dout_valid && !empty.
  - Both rspN_rd = unit_dout_rd.
  - unit_dout_ready = rsp[head]_ready && !empty.
  - The non-head port's rsp_valid = 0.
- Response transfer pops the FIFO head.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointer wrap: the pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- unit_dout_valid while empty is a protocol violation. The arbiter keeps unit_dout_ready = 0 and raises no rsp_valid.
- Latency: zero added cycles in either direction (pure muxing). Throughput is one issue per cycle while not full.
- Reset, asynchronous:
  - Clears prio, lock, pointers and count.
  - All outputs go to 0: all valids, all readies, and the data muxes (port 0 selected, gated).
  - Reset mid-operation discards all in-flight IDs. The shared unit must be reset by the same signal.

Test Plan:
- Port 0 only: insn=0x40007033 (andn), rs1=0xF0F0F0F0, rs2=0xFF00FF00 -> unit receives the operation unchanged in the same cycle; rsp0_rd=0x00F000F0; rsp1_valid stays 0.
- Both ports valid every cycle, unit and responses always ready -> issue order 0,1,0,1,...; each result appears only on its owner's rsp port, in order.
- unit_din_ready held 0 for 3 cycles while port 0 is presented and port 1 asserts valid in cycle 2 -> grant stays on port 0 until accepted, then port 1 issues next cycle.
- rsp0_ready and rsp1_ready held 0, 6 back-to-back requests with DEPTH=4 -> exactly 4 issues; 5th blocked with unit_din_valid=0; one pop then allows one more issue the following cycle.
- Head owned by port 1 with rsp1_ready=0, rsp0_ready=1 -> unit_dout_ready=0 and rsp0_valid=0 (no reordering); releasing rsp1_ready drains in issue order.
- Reset asserted asynchronously with 3 operations outstanding -> all outputs 0 immediately; after release, count=0, prio=0, and first issue is port 0 when both ports request.

Source files
------------

// File: rtl/rvb_zbb32_arbiter.sv
// Round-robin share of one in-order rvb_zbb32 unit between two requesters; zero added latency both ways.
// Backpressure: issue stalls on unit_din_ready or a full ID FIFO; results stall on the owner's rsp_ready.
module rvb_zbb32_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic [31:0]     req0_insn,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_rd,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    input  logic [31:0]     req1_insn,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_rd,
    output logic            unit_din_valid,
    input  logic            unit_din_ready,
    output logic [XLEN-1:0] unit_din_rs1,
    output logic [XLEN-1:0] unit_din_rs2,
    output logic [31:0]     unit_din_insn,
    input  logic            unit_dout_valid,
    output logic            unit_dout_ready,
    input  logic [XLEN-1:0] unit_dout_rd
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic             prio;
    logic             lock;
    logic             lock_id;
    logic [DEPTH-1:0] id_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic grant;
    logic sel_valid;
    logic full;
    logic empty;
    logic head;
    logic issue;
    logic retire;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign head   = id_q[rd_ptr];
    assign issue  = unit_din_valid && unit_din_ready;
    assign retire = unit_dout_valid && unit_dout_ready;

    always_comb begin
        grant = prio;
        if (lock)
            grant = lock_id;
        else if (req0_valid && !req1_valid)
            grant = 1'b0;
        else if (req1_valid && !req0_valid)
            grant = 1'b1;

        sel_valid      = grant ? req1_valid : req0_valid;
        unit_din_valid = !reset && sel_valid && !full;
        req0_ready     = !reset && !grant && unit_din_ready && !full;
        req1_ready     = !reset &&  grant && unit_din_ready && !full;

        unit_din_rs1  = '0;
        unit_din_rs2  = '0;
        unit_din_insn = '0;
        if (!reset) begin
            unit_din_rs1  = grant ? req1_rs1  : req0_rs1;
            unit_din_rs2  = grant ? req1_rs2  : req0_rs2;
            unit_din_insn = grant ? req1_insn : req0_insn;
        end
    end

    // A response with nothing outstanding is never forwarded or acknowledged.
    always_comb begin
        rsp0_valid      = !reset && !empty && !head && unit_dout_valid;
        rsp1_valid      = !reset && !empty &&  head && unit_dout_valid;
        unit_dout_ready = !reset && !empty && (head ? rsp1_ready : rsp0_ready);
        rsp0_rd         = reset ? '0 : unit_dout_rd;
        rsp1_rd         = reset ? '0 : unit_dout_rd;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio    <= 1'b0;
            lock    <= 1'b0;
            lock_id <= 1'b0;
            id_q    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (issue) begin
                id_q[wr_ptr] <= grant;
                wr_ptr       <= wr_ptr + 1'b1;
                prio         <= ~grant;
                lock         <= 1'b0;
            end else if (unit_din_valid) begin
                // Freeze the grant so the payload seen by the unit cannot change mid-handshake.
                lock    <= 1'b1;
                lock_id <= grant;
            end
            if (retire)
                rd_ptr <= rd_ptr + 1'b1;
            case ({issue, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_rvb_zbb32_arbiter.sv
// Directed bench for rvb_zbb32_arbiter; the bench itself plays the shared unit on the unit_* ports.
module tb_rvb_zbb32_arbiter;
    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            req0_valid = 0, req1_valid = 0;
    logic            req0_ready, req1_ready;
    logic [XLEN-1:0] req0_rs1 = '0, req0_rs2 = '0, req1_rs1 = '0, req1_rs2 = '0;
    logic [31:0]     req0_insn = '0, req1_insn = '0;
    logic            rsp0_valid, rsp1_valid;
    logic            rsp0_ready = 0, rsp1_ready = 0;
    logic [XLEN-1:0] rsp0_rd, rsp1_rd;
    logic            unit_din_valid;
    logic            unit_din_ready = 0;
    logic [XLEN-1:0] unit_din_rs1, unit_din_rs2;
    logic [31:0]     unit_din_insn;
    logic            unit_dout_valid = 0;
    logic            unit_dout_ready;
    logic [XLEN-1:0] unit_dout_rd = '0;

    int vectors     = 0;
    int miscompares = 0;

    rvb_zbb32_arbiter #(.XLEN(XLEN), .DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1),
        .req0_rs2(req0_rs2), .req0_insn(req0_insn),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rd(rsp0_rd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1),
        .req1_rs2(req1_rs2), .req1_insn(req1_insn),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rd(rsp1_rd),
        .unit_din_valid(unit_din_valid), .unit_din_ready(unit_din_ready),
        .unit_din_rs1(unit_din_rs1), .unit_din_rs2(unit_din_rs2), .unit_din_insn(unit_din_insn),
        .unit_dout_valid(unit_dout_valid), .unit_dout_ready(unit_dout_ready),
        .unit_dout_rd(unit_dout_rd)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; unit_din_ready = 0; unit_dout_valid = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin : stim
        int n0, n1, owner;

        // Outputs held at zero during reset even with a requester and the unit ready.
        req0_valid = 1; req0_rs1 = 32'h1234_5678; unit_din_ready = 1;
        #2;
        chk("rst_din_valid", unit_din_valid, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_din_rs1", unit_din_rs1, 0);
        chk("rst_dout_ready", unit_dout_ready, 0);
        do_reset();

        // Port 0 alone: andn passes through in the same cycle, result back on port 0.
        req0_valid = 1; req0_rs1 = 32'hF0F0_F0F0; req0_rs2 = 32'hFF00_FF00;
        req0_insn = 32'h4000_7033; unit_din_ready = 1; rsp0_ready = 1; rsp1_ready = 1;
        #1;
        chk("p0_din_valid", unit_din_valid, 1);
        chk("p0_din_rs1", unit_din_rs1, 32'hF0F0_F0F0);
        chk("p0_din_rs2", unit_din_rs2, 32'hFF00_FF00);
        chk("p0_din_insn", unit_din_insn, 32'h4000_7033);
        chk("p0_req0_ready", req0_ready, 1);
        chk("p0_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 0;
        unit_dout_valid = 1; unit_dout_rd = 32'h00F0_00F0;
        #1;
        chk("p0_rsp0_valid", rsp0_valid, 1);
        chk("p0_rsp0_rd", rsp0_rd, 32'h00F0_00F0);
        chk("p0_rsp1_valid", rsp1_valid, 0);
        chk("p0_dout_ready", unit_dout_ready, 1);
        tick();
        unit_dout_valid = 0;

        // Both ports always valid: alternate 0,1,0,1 until the FIFO fills.
        do_reset();
        n0 = 0; n1 = 0;
        req0_valid = 1; req1_valid = 1; unit_din_ready = 1; rsp0_ready = 0; rsp1_ready = 0;
        req0_rs1 = 32'h1000_0000; req1_rs1 = 32'h2000_0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_req0_ready", req0_ready, (k % 2 == 0) ? 1 : 0);
            chk("rr_req1_ready", req1_ready, (k % 2 == 1) ? 1 : 0);
            chk("rr_din_rs1", unit_din_rs1,
                (k % 2 == 0) ? 32'h1000_0000 + n0 : 32'h2000_0000 + n1);
            tick();
            if (k % 2 == 0) begin n0++; req0_rs1 = 32'h1000_0000 + n0; end
            else begin n1++; req1_rs1 = 32'h2000_0000 + n1; end
        end
        #1;
        chk("full_din_valid", unit_din_valid, 0);
        chk("full_req0_ready", req0_ready, 0);
        chk("full_req1_ready", req1_ready, 0);
        // Pop one while full: no issue in the same cycle.
        rsp0_ready = 1; rsp1_ready = 1;
        unit_dout_valid = 1; unit_dout_rd = 32'h0000_0100;
        #1;
        chk("pop_rsp0_valid", rsp0_valid, 1);
        chk("pop_rsp0_rd", rsp0_rd, 32'h0000_0100);
        chk("pop_din_valid", unit_din_valid, 0);
        tick();
        unit_dout_valid = 0;
        #1;
        chk("refill_din_valid", unit_din_valid, 1);
        chk("refill_req0_ready", req0_ready, 1);
        chk("refill_din_rs1", unit_din_rs1, 32'h1000_0002);
        tick();
        #1;
        chk("refull_din_valid", unit_din_valid, 0);
        req0_valid = 0; req1_valid = 0;
        // Remaining owners in issue order: 1,0,1,0.
        for (int i = 0; i < 4; i++) begin
            owner = (i % 2 == 0) ? 1 : 0;
            unit_dout_valid = 1; unit_dout_rd = 32'h200 + i;
            #1;
            chk("drain_rsp0_valid", rsp0_valid, (owner == 0) ? 1 : 0);
            chk("drain_rsp1_valid", rsp1_valid, (owner == 1) ? 1 : 0);
            chk("drain_rd", (owner == 0) ? rsp0_rd : rsp1_rd, 32'h200 + i);
            tick();
        end
        unit_dout_valid = 0;
        #1;
        chk("drained_dout_ready", unit_dout_ready, 0);

        // Lock: port 0 stalled by the unit keeps the grant although prio favours port 1.
        do_reset();
        rsp0_ready = 1; rsp1_ready = 1; unit_din_ready = 1;
        req0_valid = 1; req0_rs1 = 32'h0000_0001;
        tick();                        // issue from port 0, prio becomes 1
        unit_dout_valid = 1; unit_dout_rd = 32'h0000_0011;
        req0_rs1 = 32'h0000_AAAA; unit_din_ready = 0;
        tick();                        // result popped, port 0 presented and stalled
        unit_dout_valid = 0;
        req1_valid = 1; req1_rs1 = 32'h0000_BBBB;
        #1;
        chk("lock_din_rs1_c2", unit_din_rs1, 32'h0000_AAAA);
        chk("lock_req1_ready_c2", req1_ready, 0);
        tick();
        #1;
        chk("lock_din_rs1_c3", unit_din_rs1, 32'h0000_AAAA);
        unit_din_ready = 1;
        #1;
        chk("lock_req0_ready", req0_ready, 1);
        chk("lock_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 0;
        #1;
        chk("after_lock_rs1", unit_din_rs1, 32'h0000_BBBB);
        chk("after_lock_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0;

        // FIFO holds owners 0,1. Drain 0, then head 1 blocked by rsp1_ready.
        unit_dout_valid = 1; unit_dout_rd = 32'h0000_0A0A;
        #1;
        chk("hol_first_rsp0_valid", rsp0_valid, 1);
        tick();
        rsp1_ready = 0; unit_dout_rd = 32'h0000_0B0B;
        #1;
        chk("hol_dout_ready", unit_dout_ready, 0);
        chk("hol_rsp0_valid", rsp0_valid, 0);
        chk("hol_rsp1_valid", rsp1_valid, 1);
        tick();
        #1;
        chk("hol_still_rsp1", rsp1_valid, 1);
        rsp1_ready = 1;
        #1;
        chk("hol_release_ready", unit_dout_ready, 1);
        chk("hol_release_rd", rsp1_rd, 32'h0000_0B0B);
        tick();
        // Spurious unit response with nothing outstanding.
        #1;
        chk("empty_dout_ready", unit_dout_ready, 0);
        chk("empty_rsp0_valid", rsp0_valid, 0);
        chk("empty_rsp1_valid", rsp1_valid, 0);
        unit_dout_valid = 0;

        // Async reset with three ops outstanding.
        req0_valid = 1; req0_rs1 = 32'h0000_CCCC;
        tick(); tick(); tick();
        unit_dout_valid = 1;
        #1;
        chk("pre_rst_rsp0_valid", rsp0_valid, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_din_valid", unit_din_valid, 0);
        chk("arst_req0_ready", req0_ready, 0);
        chk("arst_rsp0_valid", rsp0_valid, 0);
        chk("arst_dout_ready", unit_dout_ready, 0);
        chk("arst_din_rs1", unit_din_rs1, 0);
        chk("arst_count", 32'(dut.count), 0);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("post_rst_rsp0_valid", rsp0_valid, 0);
        unit_dout_valid = 0;
        req1_valid = 1; req1_rs1 = 32'h0000_DDDD;
        #1;
        chk("post_rst_req0_ready", req0_ready, 1);
        chk("post_rst_req1_ready", req1_ready, 0);
        chk("post_rst_din_rs1", unit_din_rs1, 32'h0000_CCCC);
        tick();
        req0_valid = 0; req1_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
